// File: rtl/leaf_stage_pkg.sv
// Shared types for the leaf accumulator stage.
// Holds the FSM state enum and the group-count width.
package leaf_stage_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/leaf_hold_reg.sv
// Output register for the leaf accumulator: captures one group result
// and holds it until downstream accepts it.
// Ports:
//   clk, rst   - clock, async active-high reset
//   i_load     - capture payload, raise o_valid
//   i_sum, i_cnt, i_sat - payload to capture
//   i_ready    - downstream accepts (transfer when o_valid && i_ready)
//   o_valid, o_sum, o_cnt, o_sat - registered result
module leaf_hold_reg #(
  parameter int SW = 11,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [SW-1:0] i_sum,
  input  logic [CW-1:0] i_cnt,
  input  logic          i_sat,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [SW-1:0] o_sum,
  output logic [CW-1:0] o_cnt,
  output logic          o_sat
);

  logic          r_valid;
  logic [SW-1:0] r_sum;
  logic [CW-1:0] r_cnt;
  logic          r_sat;

  // Load only arrives while empty, so it never races a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_sum   <= i_sum;
      r_cnt   <= i_cnt;
      r_sat   <= i_sat;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_cnt   = r_cnt;
  assign o_sat   = r_sat;

endmodule

// File: rtl/leaf_accum_stage.sv
// Leaf accumulator: sums groups of up to N unsigned words and emits
// each group sum with its word count through a valid/ready register.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   in_valid, in_data, in_ready - input word handshake
//   flush                       - close the current partial group
//   out_valid, out_ready        - result handshake
//   out_sum, out_cnt, out_sat   - group sum, word count, clamp flag
// Build option: LEAF_ACCUM_STAGE_SAT_EN clamps the running sum at
// 2**DW-1 and reports it on out_sat; otherwise out_sat is 0.
import leaf_stage_pkg::*;

module leaf_accum_stage #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DW-1:0]           in_data,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [DW+$clog2(N):0]   out_sum,
  output logic [CNT_W-1:0]        out_cnt,
  output logic                    out_sat,
  input  logic                    out_ready
);

  localparam int SW = DW + $clog2(N) + 1;
  localparam logic [CNT_W-1:0] C_N = CNT_W'(N);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_acc;
  logic [SW-1:0]    w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SW-1:0]    w_din;
  logic [SW-1:0]    w_sum;
  logic             w_xfer;
  logic             w_load;
  logic             w_sat_nxt;

  assign in_ready = (r_state != HOLD);
  assign w_xfer   = in_valid & in_ready;
  assign w_din    = SW'(in_data);
  // SW has headroom for N full-scale words, so this never wraps.
  assign w_sum    = r_acc + w_din;

`ifdef LEAF_ACCUM_STAGE_SAT_EN
  localparam logic [SW-1:0] C_MAX = SW'({DW{1'b1}});
  logic r_sat;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
`ifdef LEAF_ACCUM_STAGE_SAT_EN
    w_sat_nxt   = r_sat;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_acc_nxt = w_din;
          w_cnt_nxt = CNT_W'(1);
`ifdef LEAF_ACCUM_STAGE_SAT_EN
          w_sat_nxt = 1'b0;
`endif
          if (N == 1 || flush) w_state_nxt = HOLD;
          else                 w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_xfer) begin
          w_acc_nxt = w_sum;
`ifdef LEAF_ACCUM_STAGE_SAT_EN
          if (w_sum > C_MAX) begin
            w_acc_nxt = C_MAX;
            w_sat_nxt = 1'b1;
          end
`endif
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_cnt_nxt == C_N || flush) w_state_nxt = HOLD;
        end else if (flush) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifndef LEAF_ACCUM_STAGE_SAT_EN
  assign w_sat_nxt = 1'b0;
`endif

  // The result register is filled on the same edge the FSM enters HOLD.
  assign w_load = (r_state != HOLD) && (w_state_nxt == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef LEAF_ACCUM_STAGE_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sat <= 1'b0;
    else     r_sat <= w_sat_nxt;
  end
`endif

  leaf_hold_reg #(
    .SW(SW),
    .CW(CNT_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_sum   (w_acc_nxt),
    .i_cnt   (w_cnt_nxt),
    .i_sat   (w_sat_nxt),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_sum   (out_sum),
    .o_cnt   (out_cnt),
    .o_sat   (out_sat)
  );

endmodule

// File: tb/tb_leaf_accum_stage.sv
// Directed bench for leaf_accum_stage (DW=8, N=4): vector table plus
// hand sequences for backpressure, idle flush, reset and saturation.
module tb_leaf_accum_stage;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int SW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [SW-1:0] out_sum;
  logic [4:0]    out_cnt;
  logic          out_sat;
  logic          out_ready;

  int total = 0;
  int bad   = 0;

  leaf_accum_stage #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          f;
    logic          r;
    logic          eir;
    logic          eov;
    logic          pay;
    logic [SW-1:0] es;
    logic [4:0]    ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int d, input logic f,
                       input logic r);
    in_valid  = v;
    in_data   = DW'(d);
    flush     = f;
    out_ready = r;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic v, input int d, input logic f,
                              input logic r, input logic eir,
                              input logic eov, input logic pay,
                              input int es, input int ec);
    vec_t t;
    t.v = v; t.d = DW'(d); t.f = f; t.r = r;
    t.eir = eir; t.eov = eov; t.pay = pay;
    t.es = SW'(es); t.ec = 5'(ec);
    return t;
  endfunction

  int exp_sum;
  int exp_sat;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);

    // basic 1,2,3,4
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 10, 4));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // 7,9 then flush with 5
    tbl.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 21, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // flush with word in IDLE -> 1-word group
    tbl.push_back(mk(1, 6, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 6, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // flush alone in ACCUM
    tbl.push_back(mk(1, 3, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // flush on the N-th word: still one group
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 4, 4));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));

    repeat (2) tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_sat", out_sat, 0);
    rst = 1'b0;
    #1;
    chk("rst_ir", in_ready, 1);
    tick();

    foreach (tbl[i]) begin
      chk($sformatf("v%0d_ir", i), in_ready, tbl[i].eir);
      chk($sformatf("v%0d_ov", i), out_valid, tbl[i].eov);
      if (tbl[i].pay) begin
        chk($sformatf("v%0d_sum", i), out_sum, tbl[i].es);
        chk($sformatf("v%0d_cnt", i), out_cnt, tbl[i].ec);
        chk($sformatf("v%0d_sat", i), out_sat, 0);
      end
      drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      tick();
    end

    // backpressure: 255 x4, downstream stalls 5 cycles
    for (int k = 0; k < 4; k++) begin
      drive(1, 255, 0, 0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_ov", out_valid, 1);
      chk("bp_ir", in_ready, 0);
      chk("bp_sum", out_sum, 1020);
      chk("bp_cnt", out_cnt, 4);
      drive(1, 99, 0, 0);
      tick();
    end
    chk("bp_ov_last", out_valid, 1);
    drive(0, 0, 0, 1);
    tick();
    chk("bp_done_ov", out_valid, 0);
    chk("bp_done_ir", in_ready, 1);

    // flush in IDLE with no word
    drive(0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      chk("idle_fl_ov", out_valid, 0);
      tick();
    end

    // async reset mid-group
    drive(1, 1, 0, 1);
    tick();
    drive(1, 2, 0, 1);
    tick();
    drive(0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ir", in_ready, 1);
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_cnt", out_cnt, 0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_ov", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    chk("post_rst_vld", out_valid, 1);
    chk("post_rst_sum", out_sum, 4);
    chk("post_rst_cnt", out_cnt, 4);
    tick();
    chk("post_rst_idle", out_valid, 0);

    // saturation: 200 + 100 then flush
`ifdef LEAF_ACCUM_STAGE_SAT_EN
    exp_sum = 255;
    exp_sat = 1;
`else
    exp_sum = 300;
    exp_sat = 0;
`endif
    drive(1, 200, 0, 0);
    tick();
    drive(1, 100, 0, 0);
    tick();
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("sat_ov", out_valid, 1);
    chk("sat_sum", out_sum, exp_sum);
    chk("sat_flag", out_sat, exp_sat);
    chk("sat_cnt", out_cnt, 2);
    drive(0, 0, 0, 1);
    tick();
    chk("sat_done", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_accum_stage.md
LEAF_ACCUM_STAGE -- requirements
Module: leaf_accum_stage

Interface
REQ-001 The block SHALL have parameter DW, default 8, the input data width in bits.
REQ-002 The block SHALL have parameter N, default 4, the number of words per group (legal range 1..16).
REQ-003 The block SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, width 1: the input word is valid.
REQ-006 The block SHALL have port in_data, input, width DW: the input word, unsigned.
REQ-007 The block SHALL have port in_ready, output, width 1: the stage accepts a word this cycle.
REQ-008 The block SHALL have port flush, input, width 1: close the current partial group.
REQ-009 The block SHALL have port out_valid, output, width 1: the result is valid.
REQ-010 The block SHALL have port out_sum, output, width SW = DW+$clog2(N)+1: the group sum.
REQ-011 The block SHALL have port out_cnt, output, width 5: the number of words in the group.
REQ-012 The block SHALL have port out_sat, output, width 1: the sum was clamped (macro builds only, else tied 0).
REQ-013 The block SHALL have port out_ready, input, width 1: downstream accepts the result.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready on a rising edge, and an output transfer when out_valid && out_ready.
REQ-015 The FSM SHALL have states IDLE, ACCUM and HOLD.
REQ-016 In IDLE and ACCUM, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-017 On an input transfer in IDLE, acc SHALL load in_data and cnt SHALL load 1; the next state SHALL be HOLD if N==1, else ACCUM.
REQ-018 On an input transfer in ACCUM, acc SHALL become acc+in_data and cnt SHALL become cnt+1; when the new cnt equals N, the next state SHALL be HOLD.
REQ-019 flush in ACCUM SHALL move the FSM to HOLD at the next edge with the current partial group.
REQ-020 If flush and an input transfer coincide in ACCUM, the word SHALL be included before entering HOLD.
REQ-021 flush in IDLE or HOLD SHALL be ignored, and no empty group SHALL be emitted.
REQ-022 In IDLE, flush together with an input transfer SHALL emit a 1-word group, entering HOLD.
REQ-023 In HOLD, out_sum=acc and out_cnt=cnt SHALL be held stable until the output transfer, then the FSM SHALL return to IDLE.
REQ-024 Latency from the N-th accepted word to out_valid SHALL be 1 cycle.
REQ-025 Throughput SHALL be at most one group per N+1 cycles, because the HOLD cycle blocks input.
REQ-026 The arithmetic SHALL be unsigned; SW bits SHALL never overflow without the macro.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, acc=0, cnt=0, out_valid=0, in_ready=1 (after release), out_sum=0, out_cnt=0 and out_sat=0.
REQ-028 Reset mid-group or mid-HOLD SHALL discard the pending group, and no output transfer SHALL follow.

Configuration
REQ-029 The macro LEAF_ACCUM_STAGE_SAT_EN SHALL select saturation behaviour.
REQ-030 With LEAF_ACCUM_STAGE_SAT_EN defined, any add producing acc > 2**DW-1 SHALL clamp acc to 2**DW-1 and set a sticky sat flag, cleared on group start.
REQ-031 With LEAF_ACCUM_STAGE_SAT_EN defined, out_sat SHALL present the sat flag in HOLD.
REQ-032 Without LEAF_ACCUM_STAGE_SAT_EN, the block SHALL perform full-width accumulation with no clamp logic, and out_sat SHALL be constant 0.

Structure
REQ-033 The shared package leaf_stage_pkg SHALL hold the FSM state enum (IDLE/ACCUM/HOLD) and the CNT_W=5 constant.
REQ-034 The output register and handshake SHALL live in one sub-module, leaf_hold_reg, which holds payload while out_valid && !out_ready.

Verification
REQ-035 The bench SHALL cover basic operation: DW=8, N=4, words 1,2,3,4 back-to-back with out_ready=1 -> out_valid 1 cycle after the 4th word, out_sum=10, out_cnt=4, then IDLE.
REQ-036 The bench SHALL cover backpressure: group 255x4 with out_ready=0 for 5 cycles -> out_sum=1020 stable, in_ready=0 throughout, transfer on the first out_ready=1.
REQ-037 The bench SHALL cover flush: words 7,9 then flush together with word 5 -> out_sum=21, out_cnt=3.
REQ-038 The bench SHALL cover idle flush: flush with in_valid=0 in IDLE -> no out_valid for 10 cycles.
REQ-039 The bench SHALL cover reset mid-group: 2 words accepted, then rst pulsed asynchronously between edges -> out_valid=0 immediately; the next group of 1,1,1,1 gives out_sum=4.
REQ-040 The bench SHALL cover saturation with the macro defined: words 200,100 then flush -> out_sum=255, out_sat=1; without the macro -> out_sum=300, out_sat=0.
